instruction_fetch_unit: RTL

Sequential instruction producer that feeds the opcode-driven control unit and register file. Holds the program counter, runs a read handshake against instruction memory, latches each 32-bit instruction word, and presents the decoded fields (opcode, destination, sources/immediate) with a valid strobe. It also computes the next PC, with optional PC-relative branching.

---
 rtl/instruction_fetch_unit_if.sv | 24 ++
 rtl/instruction_fetch_unit.sv | 119 +++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory read port between the fetch unit (master) and memory (slave).
// The request holds addr/read until the memory drops busywait.
interface instruction_fetch_unit_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic [PC_WIDTH-1:0] addr;
    logic                read;
    logic [31:0]         rdata;
    logic                busywait;

    modport master (
        output addr,
        output read,
        input  rdata,
        input  busywait
    );

    modport slave (
        input  addr,
        input  read,
        output rdata,
        output busywait
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads instruction memory, latches the word into IR
// and issues its decoded fields with a valid strobe; computes next PC with optional branch.
module instruction_fetch_unit #(
    parameter int unsigned         PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                      CLK,
    input  logic                      RESET,
    instruction_fetch_unit_if.master  imem,
    input  logic                      stall,
    input  logic                      branch_taken,
    input  logic [7:0]                branch_offset,
    output logic [PC_WIDTH-1:0]       pc,
    output logic [7:0]                opcode,
    output logic [7:0]                rd,
    output logic [7:0]                rt,
    output logic [7:0]                rs_imm,
    output logic                      instr_valid
);

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned OFF_WIDTH  = 8;
    localparam int unsigned EXT_WIDTH  = PC_WIDTH - OFF_WIDTH - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_e;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] rd;
        logic [7:0] rt;
        logic [7:0] rs_imm;
    } instr_t;

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    instr_t              ir_q, ir_d;
    logic                read_q, read_d;
    logic                valid_q, valid_d;

    logic [PC_WIDTH-1:0] branch_disp;
    logic [PC_WIDTH-1:0] next_pc;

    // Word offset is sign-extended and scaled to bytes; wraps modulo 2^PC_WIDTH.
    always_comb begin
        branch_disp = {{EXT_WIDTH{branch_offset[OFF_WIDTH-1]}}, branch_offset, 2'b00};
        next_pc     = pc_q + PC_WIDTH'(WORD_BYTES);
        if (branch_taken) begin
            next_pc = next_pc + branch_disp;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        read_d  = read_q;
        valid_d = valid_q;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
                read_d  = 1'b1;
                valid_d = 1'b0;
            end
            FETCH: begin
                if (!imem.busywait) begin
                    ir_d    = instr_t'(imem.rdata);
                    read_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // A stall freezes everything, including the branch decision.
                if (!stall) begin
                    pc_d    = next_pc;
                    read_d  = 1'b1;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            read_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            read_q  <= read_d;
            valid_q <= valid_d;
        end
    end

    assign imem.addr   = pc_q;
    assign imem.read   = read_q;
    assign pc          = pc_q;
    assign opcode      = ir_q.opcode;
    assign rd          = ir_q.rd;
    assign rt          = ir_q.rt;
    assign rs_imm      = ir_q.rs_imm;
    assign instr_valid = valid_q;

endmodule
